// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised button sequence detector:
// symbol encodings, default pattern and the accept-decision encoding.
package seq_det_pkg;

  localparam logic SYM_ONE  = 1'b1;
  localparam logic SYM_ZERO = 1'b0;

  localparam int unsigned                DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0]     DEF_PATTERN = 4'b1100;

  // Outcome of one cycle of button edges.
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_ONE,
    ACC_ZERO,
    ACC_CONFLICT
  } acc_e;

endpackage

// File: rtl/seq_detector_param_btn_edge_det.sv
// Rising-edge detector for one synchronised button level.
// The register resets high so a button held through reset release
// does not produce an edge.
module btn_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic lvl,
  output logic rise
);

  logic lvl_q;

  // Previous-cycle level, forced high during reset.
  always_ff @(posedge clk) begin
    if (reset) lvl_q <= 1'b1;
    else       lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore sequence detector fed by two button strobes
// (P1 = '1', P2 = '0'). z is high while the last PAT_LEN accepted
// symbols equal PATTERN; fill reports history depth for the LEDs.
// Optional feature macro: SEQ_DET_MATCH_CNT_EN adds the saturating
// match_cnt output.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_LEN = DEF_PAT_LEN,
  parameter              PATTERN = DEF_PATTERN,
  parameter bit          OVERLAP = 1'b1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         P1,
  input  logic                         P2,
  output logic                         z,
  output logic [$clog2(PAT_LEN+1)-1:0] fill,
  output logic                         err
`ifdef SEQ_DET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]             match_cnt
`endif
);

  localparam int unsigned          FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_LEN);
  localparam logic [PAT_LEN-1:0]   PAT_V    = PAT_LEN'(PATTERN);

  // Elaboration-time parameter sanity checks.
  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN %0d outside 2..16", PAT_LEN);
  end
  if ($bits(PATTERN) != PAT_LEN) begin : g_bad_pat
    $error("seq_detector_param: PATTERN width %0d differs from PAT_LEN %0d",
           $bits(PATTERN), PAT_LEN);
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  logic e1, e2;

  btn_edge_det u_p1_edge (.clk(clk), .reset(reset), .lvl(P1), .rise(e1));
  btn_edge_det u_p2_edge (.clk(clk), .reset(reset), .lvl(P2), .rise(e2));

  acc_e                acc;
  logic                sym;
  logic [PAT_LEN-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                z_q, z_d;
  logic                err_q, err_d;

  // Classify this cycle's edges into a symbol, a conflict, or nothing.
  always_comb begin
    acc = ACC_NONE;
    sym = SYM_ZERO;
    case ({e1, e2})
      2'b10:   begin acc = ACC_ONE;  sym = SYM_ONE;  end
      2'b01:   begin acc = ACC_ZERO; sym = SYM_ZERO; end
      2'b11:   acc = ACC_CONFLICT;
      default: acc = ACC_NONE;
    endcase
  end

  // Next history/fill; z is the registered match of the next-state values,
  // so it only changes when a symbol is accepted.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    err_d  = 1'b0;
    case (acc)
      ACC_ONE, ACC_ZERO: begin
        if (!OVERLAP && z_q) begin
          hist_d    = '0;
          hist_d[0] = sym;
          fill_d    = FILL_W'(1);
        end else begin
          hist_d = {hist_q[PAT_LEN-2:0], sym};
          if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
        end
      end
      ACC_CONFLICT: err_d = 1'b1;
      default:      err_d = 1'b0;
    endcase
    z_d = (fill_d == FILL_MAX) && (hist_d == PAT_V);
  end

  // Detector state register; reset wins over any same-cycle edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
      err_q  <= err_d;
    end
  end

  assign z    = z_q;
  assign fill = fill_q;
  assign err  = err_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count rising edges of z, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (z_d && !z_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Match counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_cnt = cnt_q;
`endif

endmodule
